berger_zero_encoder_fifo: RTL

BERGER_ZERO_ENCODER_FIFO -- requirements
Module: berger_zero_encoder_fifo

---
 rtl/berger_zero_pkg.sv | 39 +++
 rtl/berger_zero_encoder.sv | 14 +
 rtl/berger_zero_encoder_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/berger_zero_pkg.sv
// Shared codeword definitions for the berger_zero encoder and decoder:
// widths, data-to-codeword bit placement and the Hamming parity equations.
package berger_zero_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CODE_W = 12;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CODE_W-1:0] code_t;

  // Codeword index holding data bit i; indices 0, 1, 3 and 7 carry parity.
  localparam int unsigned DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

  // Parity bits packed as {c7, c3, c1, c0}.
  function automatic logic [3:0] parity_bits(data_t d);
    logic [3:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return p;
  endfunction

  function automatic code_t encode(data_t d);
    code_t      c;
    logic [3:0] p;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c[DATA_POS[i]] = d[i];
    end
    p    = parity_bits(d);
    c[0] = p[0];
    c[1] = p[1];
    c[3] = p[2];
    c[7] = p[3];
    return c;
  endfunction

endpackage

// File: rtl/berger_zero_encoder.sv
// Combinational 8-bit data to 12-bit Hamming codeword encoder.
module berger_zero_encoder
  import berger_zero_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [CODE_W-1:0] o_code
);

  // Pure table/equation mapping from the shared package.
  always_comb begin
    o_code = encode(i_data);
  end

endmodule

// File: rtl/berger_zero_encoder_fifo.sv
// Encodes accepted bytes into 12-bit codewords (with optional test error
// injection) and buffers them in a DEPTH-entry FIFO for a downstream consumer.
module berger_zero_encoder_fifo
  import berger_zero_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     inj_en,
  input  logic [CODE_W-1:0]        inj_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CODE_W-1:0]        out_code,
  output logic                     out_injected,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               inj_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [7:0]       r_inj_count;
  code_t            r_mem [DEPTH];
  logic [DEPTH-1:0] r_inj_mem;

  code_t w_code;
  code_t w_store;
  logic  w_push;
  logic  w_pop;

  berger_zero_encoder u_encoder (
    .i_data (in_data),
    .o_code (w_code)
  );

  // Handshakes derive from registered occupancy only, so a pop never frees a
  // slot for a push in the same cycle.
  assign in_ready  = (r_level < LW'(DEPTH));
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_store   = w_code ^ (inj_en ? inj_mask : '0);
  assign level     = r_level;
  assign inj_count = r_inj_count;

  // Pointer, occupancy and injection-counter state; reset wins over traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_inj_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push && inj_en && (r_inj_count != 8'hFF)) begin
        r_inj_count <= r_inj_count + 1'b1;
      end
    end
  end

  // Entry storage; contents are not cleared by reset since level gates them.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr]     <= w_store;
      r_inj_mem[r_wr_ptr] <= inj_en;
    end
  end

  // Head of FIFO, forced to zero when nothing is valid.
  always_comb begin
    out_code     = '0;
    out_injected = 1'b0;
    if (out_valid) begin
      out_code     = r_mem[r_rd_ptr];
      out_injected = r_inj_mem[r_rd_ptr];
    end
  end

endmodule
